// File: rtl/apb_completer_mem_bfm_if.sv
// APB3 bus bundle shared by the initiator BFM and the memory-backed completer.
// The clock and reset are not part of the bundle; they stay plain ports on
// each side of the bus.
interface apb_completer_mem_bfm_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_completer_mem_bfm.sv
// APB3 completer BFM backed by a word-addressed RAM window at BASE_ADDR.
// Each transfer inserts WAIT_CYCLES wait states, sampled in the setup phase.
// Addresses outside the window complete with PSLVERR. ACCESS_COUNT counts
// every completed transfer, OK or error, and saturates at 16'hFFFF.
// Optional build macro APB_COMPLETER_PROTOCOL_CHECK_EN adds a sticky
// handshake-violation flag on PROT_ERR. Without the macro, PROT_ERR is
// tied low and no check logic is built.
module apb_completer_mem_bfm #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          TPD        = 1
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   apb_completer_mem_bfm_if.slave apb,
   input  logic [3:0]             WAIT_CYCLES,
   output logic [15:0]            ACCESS_COUNT,
   output logic                   PROT_ERR
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   // Output skew is left to the surrounding environment. The parameter is
   // kept so this completer takes the same parameter set as the initiator BFM.
   localparam int unused_tpd_ns = TPD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  r_state;
   logic [31:0]             r_mem [0:DEPTH-1];
   logic [31:0]             r_addr;
   logic                    r_write;
   logic [31:0]             r_wdata;
   logic                    r_hit;
   logic [3:0]              r_cnt;
   logic [31:0]             r_prdata;
   logic                    r_pready;
   logic                    r_pslverr;
   logic [15:0]             r_access_count;

   logic                    w_hit;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic [ADDR_WIDTH-1:0]   w_lat_idx;
   logic                    w_sel_hit;
   logic                    w_sel_write;
   logic [ADDR_WIDTH-1:0]   w_sel_idx;
   logic [31:0]             w_rsp_data;
   logic                    w_rsp_err;
   logic                    w_unused_bits;

   // Window decode on the live bus (used in setup) and on the latched address.
   assign w_hit     = (apb.PADDR[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign w_idx     = apb.PADDR[ADDR_WIDTH+1:2];
   assign w_lat_idx = r_addr[ADDR_WIDTH+1:2];

   // The response is built from the live bus in IDLE (zero-wait setup).
   // After that it is built from the fields latched at setup.
   assign w_sel_hit   = (r_state == ST_IDLE) ? w_hit       : r_hit;
   assign w_sel_write = (r_state == ST_IDLE) ? apb.PWRITE  : r_write;
   assign w_sel_idx   = (r_state == ST_IDLE) ? w_idx       : w_lat_idx;
   assign w_rsp_data  = (!w_sel_write && w_sel_hit) ? r_mem[w_sel_idx] : 32'h0000_0000;
   assign w_rsp_err   = !w_sel_hit;

   // Byte-lane bits and the window-compare bits of the latched address are
   // intentionally not consumed by the datapath.
   assign w_unused_bits = &{1'b0, apb.PADDR[1:0], r_addr[1:0], r_addr[31:ADDR_WIDTH+2]};

   // Transfer FSM: setup latch, wait-state countdown, completion, memory and counter update.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state        <= ST_IDLE;
         r_addr         <= 32'h0000_0000;
         r_write        <= 1'b0;
         r_wdata        <= 32'h0000_0000;
         r_hit          <= 1'b0;
         r_cnt          <= 4'd0;
         r_prdata       <= 32'h0000_0000;
         r_pready       <= 1'b0;
         r_pslverr      <= 1'b0;
         r_access_count <= 16'h0000;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= 32'h0000_0000;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (apb.PSEL && !apb.PENABLE) begin
                  r_addr  <= apb.PADDR;
                  r_write <= apb.PWRITE;
                  r_wdata <= apb.PWDATA;
                  r_hit   <= w_hit;
                  r_cnt   <= WAIT_CYCLES;
                  if (WAIT_CYCLES == 4'd0) begin
                     r_state   <= ST_DONE;
                     r_pready  <= 1'b1;
                     r_pslverr <= w_rsp_err;
                     r_prdata  <= w_rsp_data;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!apb.PSEL) begin
                  r_state   <= ST_IDLE;
                  r_pready  <= 1'b0;
                  r_pslverr <= 1'b0;
                  r_prdata  <= 32'h0000_0000;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     r_state   <= ST_DONE;
                     r_pready  <= 1'b1;
                     r_pslverr <= w_rsp_err;
                     r_prdata  <= w_rsp_data;
                  end
               end
            end
            ST_DONE: begin
               if (!apb.PSEL) begin
                  r_state   <= ST_IDLE;
                  r_pready  <= 1'b0;
                  r_pslverr <= 1'b0;
                  r_prdata  <= 32'h0000_0000;
               end else if (apb.PENABLE && r_pready) begin
                  if (r_write && r_hit) begin
                     r_mem[w_lat_idx] <= r_wdata;
                  end
                  if (r_access_count != 16'hFFFF) begin
                     r_access_count <= r_access_count + 16'd1;
                  end
                  r_state   <= ST_IDLE;
                  r_pready  <= 1'b0;
                  r_pslverr <= 1'b0;
                  r_prdata  <= 32'h0000_0000;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
               r_prdata  <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign apb.PRDATA   = r_prdata;
   assign apb.PREADY   = r_pready;
   assign apb.PSLVERR  = r_pslverr;
   assign ACCESS_COUNT = r_access_count;

`ifdef APB_COMPLETER_PROTOCOL_CHECK_EN
   logic r_prot_err;
   logic w_viol_no_sel;
   logic w_viol_no_setup;
   logic w_viol_unstable;
   logic w_viol;

   assign w_viol_no_sel   = apb.PENABLE && !apb.PSEL;
   assign w_viol_no_setup = apb.PENABLE && apb.PSEL && (r_state == ST_IDLE);
   assign w_viol_unstable = apb.PSEL && ((r_state == ST_WAIT) || (r_state == ST_DONE)) &&
                            ((apb.PADDR != r_addr) || (apb.PWRITE != r_write) ||
                             (apb.PWDATA != r_wdata));
   assign w_viol          = w_viol_no_sel || w_viol_no_setup || w_viol_unstable;

   // Hold any handshake violation until reset and report each occurrence.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_prot_err <= 1'b0;
      end else if (w_viol) begin
         r_prot_err <= 1'b1;
         $display("%0t apb_completer_mem_bfm: protocol violation (enable_without_sel=%0b no_setup=%0b unstable=%0b)",
                  $time, w_viol_no_sel, w_viol_no_setup, w_viol_unstable);
      end else begin
         r_prot_err <= r_prot_err;
      end
   end

   assign PROT_ERR = r_prot_err;
`else
   assign PROT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_completer_mem_bfm.sv
// Directed self-checking bench for apb_completer_mem_bfm.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled at
// that same point, before the new values are applied.
module tb_apb_completer_mem_bfm;

   localparam int unsigned AW   = 8;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        preset;
   logic [3:0]  wait_cycles;
   logic [15:0] access_count;
   logic        prot_err;

   int n_checks = 0;
   int n_fails  = 0;

   apb_completer_mem_bfm_if apb_if();

   apb_completer_mem_bfm #(
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE),
      .TPD        (1)
   ) dut (
      .PCLK         (clk),
      .PRESET       (preset),
      .apb          (apb_if),
      .WAIT_CYCLES  (wait_cycles),
      .ACCESS_COUNT (access_count),
      .PROT_ERR     (prot_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One APB transfer. The wait count is changed to 0 right after setup,
   // which the DUT must ignore. The task leaves the bus deselected, so
   // consecutive calls run back to back with no idle cycle.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] waits, output logic [31:0] rdata,
                       output logic err, output int cycles);
      apb_if.PSEL    = 1'b1;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = wr;
      apb_if.PADDR   = addr;
      apb_if.PWDATA  = wdata;
      wait_cycles    = waits;
      tick();
      wait_cycles    = 4'd0;
      apb_if.PENABLE = 1'b1;
      cycles = 0;
      rdata  = 32'h0;
      err    = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         if (apb_if.PREADY === 1'b1) begin
            cycles = k;
            rdata  = apb_if.PRDATA;
            err    = apb_if.PSLVERR;
            break;
         end
         check("prdata_zero_while_waiting", apb_if.PRDATA, 32'h0);
         tick();
      end
      check("pready_seen", {31'd0, apb_if.PREADY}, 32'd1);
      tick();
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
   endtask

   task automatic idle();
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      tick();
   endtask

   logic [31:0] rd;
   logic        er;
   int          cy;
   logic        exp_prot;

   initial begin
`ifdef APB_COMPLETER_PROTOCOL_CHECK_EN
      exp_prot = 1'b1;
`else
      exp_prot = 1'b0;
`endif
      preset         = 1'b1;
      wait_cycles    = 4'd0;
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b0;
      apb_if.PADDR   = 32'h0;
      apb_if.PWDATA  = 32'h0;
      tick();
      tick();
      check("rst_prdata",  apb_if.PRDATA, 32'h0);
      check("rst_pready",  {31'd0, apb_if.PREADY}, 32'd0);
      check("rst_pslverr", {31'd0, apb_if.PSLVERR}, 32'd0);
      check("rst_count",   {16'd0, access_count}, 32'd0);
      check("rst_prot",    {31'd0, prot_err}, 32'd0);
      preset = 1'b0;
      tick();

      // Zero-wait write then back-to-back read of the same word.
      xfer(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'd0, rd, er, cy);
      check("zw_wr_cycles", 32'(cy), 32'd1);
      check("zw_wr_err",    {31'd0, er}, 32'd0);
      check("zw_wr_ready_cleared", {31'd0, apb_if.PREADY}, 32'd0);
      xfer(1'b0, BASE + 32'h10, 32'h0, 4'd0, rd, er, cy);
      check("zw_rd_cycles", 32'(cy), 32'd1);
      check("zw_rd_data",   rd, 32'hDEAD_BEEF);
      check("zw_rd_err",    {31'd0, er}, 32'd0);
      check("zw_prdata_cleared", apb_if.PRDATA, 32'h0);
      idle();
      check("zw_count", {16'd0, access_count}, 32'd2);

      // Three wait states; the mid-transfer WAIT_CYCLES change must not matter.
      xfer(1'b0, BASE + 32'h4, 32'h0, 4'd3, rd, er, cy);
      check("ws_cycles", 32'(cy), 32'd4);
      check("ws_data",   rd, 32'h0);
      check("ws_err",    {31'd0, er}, 32'd0);
      idle();
      check("ws_count", {16'd0, access_count}, 32'd3);

      // Out of window: the error write must not alias onto index 0.
      xfer(1'b1, BASE + (32'd4 << AW), 32'h1234_5678, 4'd0, rd, er, cy);
      check("oow_wr_cycles", 32'(cy), 32'd1);
      check("oow_wr_err",    {31'd0, er}, 32'd1);
      xfer(1'b0, BASE, 32'h0, 4'd0, rd, er, cy);
      check("oow_idx0_data", rd, 32'h0);
      check("oow_idx0_err",  {31'd0, er}, 32'd0);
      xfer(1'b0, BASE + (32'd4 << AW), 32'h0, 4'd1, rd, er, cy);
      check("oow_rd_cycles", 32'(cy), 32'd2);
      check("oow_rd_data",   rd, 32'h0);
      check("oow_rd_err",    {31'd0, er}, 32'd1);
      idle();
      check("oow_count", {16'd0, access_count}, 32'd6);

      // Back-to-back zero-wait writes to indices 0..3, then read them back.
      for (int i = 0; i < 4; i++) begin
         xfer(1'b1, BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'd0, rd, er, cy);
         check("b2b_wr_cycles", 32'(cy), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         xfer(1'b0, BASE + 32'(4 * i), 32'h0, 4'd0, rd, er, cy);
         check("b2b_rd_data", rd, 32'hA000_0000 + 32'(i));
      end
      idle();
      check("b2b_count", {16'd0, access_count}, 32'd14);

      // Abort: drop PSEL during wait states of a write to index 5.
      apb_if.PSEL    = 1'b1;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b1;
      apb_if.PADDR   = BASE + 32'h14;
      apb_if.PWDATA  = 32'hCAFE_F00D;
      wait_cycles    = 4'd3;
      tick();
      apb_if.PENABLE = 1'b1;
      tick();
      check("abort_no_ready_yet", {31'd0, apb_if.PREADY}, 32'd0);
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      tick();
      check("abort_ready", {31'd0, apb_if.PREADY}, 32'd0);
      check("abort_count", {16'd0, access_count}, 32'd14);
      xfer(1'b0, BASE + 32'h14, 32'h0, 4'd0, rd, er, cy);
      check("abort_idx5", rd, 32'h0);
      idle();
      check("abort_rd_count", {16'd0, access_count}, 32'd15);

      // Reset while PREADY is high: the write to index 6 must not commit.
      apb_if.PSEL    = 1'b1;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b1;
      apb_if.PADDR   = BASE + 32'h18;
      apb_if.PWDATA  = 32'h0000_0055;
      wait_cycles    = 4'd0;
      tick();
      apb_if.PENABLE = 1'b1;
      check("rstd_ready_high", {31'd0, apb_if.PREADY}, 32'd1);
      preset = 1'b1;
      tick();
      check("rstd_ready", {31'd0, apb_if.PREADY}, 32'd0);
      check("rstd_count", {16'd0, access_count}, 32'd0);
      preset         = 1'b0;
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      tick();
      xfer(1'b0, BASE,          32'h0, 4'd0, rd, er, cy);
      check("rstd_idx0", rd, 32'h0);
      xfer(1'b0, BASE + 32'h10, 32'h0, 4'd0, rd, er, cy);
      check("rstd_idx4", rd, 32'h0);
      xfer(1'b0, BASE + 32'h18, 32'h0, 4'd2, rd, er, cy);
      check("rstd_idx6", rd, 32'h0);
      idle();
      check("rstd_rd_count", {16'd0, access_count}, 32'd3);
      check("prot_before", {31'd0, prot_err}, 32'd0);

      // PADDR changes during wait states.
      apb_if.PSEL    = 1'b1;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b1;
      apb_if.PADDR   = BASE + 32'h1C;
      apb_if.PWDATA  = 32'h0000_0077;
      wait_cycles    = 4'd3;
      tick();
      apb_if.PENABLE = 1'b1;
      tick();
      apb_if.PADDR   = BASE + 32'h20;
      tick();
      check("prot_set", {31'd0, prot_err}, {31'd0, exp_prot});
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      apb_if.PADDR   = BASE + 32'h1C;
      tick();
      tick();
      check("prot_sticky", {31'd0, prot_err}, {31'd0, exp_prot});
      preset = 1'b1;
      tick();
      preset = 1'b0;
      tick();
      check("prot_cleared", {31'd0, prot_err}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
